axi_lite_master_verifier: RTL and testbench
===========================================

Name: axi_lite_master_verifier

Overview:
Protocol verifier for the master side of an AXI-Lite link. It sits between an untrusted AXI-Lite master (e.g. a virtualized user region) and the shell's AXI-Lite slaves, and repairs common master violations so the downstream slave only ever sees legal traffic:
- valid withdrawn before the handshake completes;
- payload changed while valid is high;
- too many outstanding requests.

It also times out a master that stops accepting responses, and exports bresp_expected / rresp_expected for use by the decoupler and the slave-side verifier.

Parameters:
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 32, data width (32 or 64 only).
- BTIMEOUT_CYCLES, 127, cycles bvalid may wait for bready before a B timeout.
- RTIMEOUT_CYCLES, 127, cycles rvalid may wait for rready before an R timeout.
- OUTSTANDING_WREQ, 8, maximum write requests in flight (AW and W counted independently).
- OUTSTANDING_RREQ, 8, maximum read requests in flight.

Ports:
- aclk  in  1  single clock; all logic is synchronous to it.
- areset  in  1  reset, synchronous, active-high.
- axi_lite_s_*  —  AXI-Lite slave port; the master under test connects here. Signals aw{addr,valid,ready}, w{data,strb,valid,ready}, b{resp,valid,ready}, ar{addr,valid,ready}, r{data,resp,valid,ready}, at standard widths.
- axi_lite_m_*  —  mirror AXI-Lite master port to the downstream slave.
- timeout_error_irq  out  1  level interrupt; high if any error condition is set.
- timeout_status_vector  out  5  sticky error bits:
  - bit 0: AW violation
  - bit 1: W violation
  - bit 2: AR violation
  - bit 3: B timeout
  - bit 4: R timeout
- timeout_error_clear  in  1  single-cycle clear of all sticky bits and timers.
- bresp_expected  out  1  at least one write has both AW and W issued and no B returned yet.
- rresp_expected  out  1  at least one AR issued downstream with no R returned yet.

Behaviour:

Reset:
- All request FSMs go to IDLE.
- All counters and timers are 0.
- Sticky bits are 0.
- axi_lite_m_awvalid, axi_lite_m_wvalid, axi_lite_m_arvalid, timeout_error_irq, bresp_expected and rresp_expected are 0 in the cycle after areset is sampled.
- Reset mid-transaction drops all held requests; no completion is owed.

Request channels (AW, W, AR): each is an identical two-state FSM.
- IDLE:
  - m_valid = s_valid & ~full; m_payload = s_payload; s_ready = m_ready & ~full.
  - If m_valid & ~m_ready: capture s_payload into the hold register and go to HOLD.
- HOLD:
  - m_valid = 1; m_payload = hold register; s_ready = m_ready.
  - On m_ready: return to IDLE.
  - In any HOLD cycle, set the channel's violation bit if (a) ~s_valid, or (b) s_valid with s_payload ≠ hold register.
    - AW/AR compare addr; W compares data and strb.
  - If valid was dropped, the downstream transfer still completes and the upstream master sees no ready for it.
- Zero latency: IDLE is fully combinational pass-through.

Outstanding counters:
- aw_out, w_out and ar_out are each $clog2(N+1) bits.
- Increment on the downstream handshake of the channel.
- aw_out and w_out decrement on a B handshake (m_bvalid & s_bready); ar_out decrements on an R handshake.
- Simultaneous increment and decrement leaves the value unchanged.
- Decrement at 0 saturates at 0; an unexpected response is passed through untouched.
- full = (count == limit). This gates only new issue from IDLE; HOLD was already counted.
- bresp_expected = (aw_out ≠ 0) & (w_out ≠ 0). rresp_expected = (ar_out ≠ 0).

Response channels:
- B and R are pure pass-through.
- Timer: cleared to 0 on handshake, on clear, or on reset; otherwise increments while m_valid & ~s_ready; saturates.
- Timeout when the timer exceeds BTIMEOUT_CYCLES or RTIMEOUT_CYCLES respectively. The timer sets its sticky bit.

Error signalling:
- Sticky bits set the cycle after the condition is detected.
- Clear has priority over a same-cycle set.
- timeout_error_irq = OR of the sticky bits OR the raw B/R timeout conditions, so it rises in the detection cycle for timeouts.

Decomposition:
- Package axi_lite_verif_pkg holds:
  - hold_state_t enum {IDLE, HOLD};
  - status-bit index localparams (ST_AW=0 … ST_R=4);
  - AXI resp localparams.
- One sub-module, axi_lite_req_holder, parameterized by payload width. It contains the FSM, the hold register, the violation flag and full gating, and is instantiated three times for AW, W and AR.

Test Plan:
1. Write addr 0x10, awready held low 3 cycles, master drops awvalid after 1 cycle → m_awvalid stays 1 with addr 0x10 until awready; status[0]=1; irq=1.
2. AR valid, araddr changes 0x20→0x24 while arready=0 → m_araddr stays 0x20; status[2]=1; handshake completes with 0x20.
3. Issue 8 reads without R (OUTSTANDING_RREQ=8) → 9th arvalid sees s_arready=0 and m_arvalid=0. One R handshake → 9th issues the next cycle; rresp_expected stays 1 throughout.
4. m_bvalid=1, s_bready=0 for 128 cycles → status[3]=1 and irq high in cycle 128. Pulse timeout_error_clear → vector=0, irq=0, timer restarts.
5. Simultaneous AW+W handshake and B handshake with aw_out=w_out=1 → counts stay at 1; bresp_expected stays 1.
6. areset asserted while AW is in HOLD → next cycle m_awvalid=0, counters 0, status 0.

Source files
------------

// File: rtl/axi_lite_master_verifier_pkg.sv
// Shared definitions for the AXI-Lite master-side verifier.
//   hold_state_t : request-channel FSM states (IDLE pass-through, HOLD replay)
//   ST_*         : bit positions inside timeout_status_vector
//   RESP_*       : AXI response encodings
//   cnt_width    : width needed to count 0..n inclusive
package axi_lite_verif_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } hold_state_t;

  localparam int ST_AW    = 0;
  localparam int ST_W     = 1;
  localparam int ST_AR    = 2;
  localparam int ST_B     = 3;
  localparam int ST_R     = 4;
  localparam int ST_COUNT = 5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/axi_lite_master_verifier_if.sv
// AXI-Lite bus bundle (AW, W, B, AR, R).
//   master modport : drives requests and response readies
//   slave  modport : drives request readies and responses
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_master_verifier_req_holder.sv
// Request-channel repair stage (used for AW, W and AR).
// In IDLE the channel is a combinational pass-through gated by i_full.
// Once a request is offered downstream without being accepted, the payload
// is frozen in a hold register and replayed until the downstream ready,
// regardless of what the upstream master does meanwhile.
//   i_aclk, i_areset        : clock, synchronous active-high reset
//   i_s_valid/i_s_payload   : request from the untrusted master
//   o_s_ready               : ready returned to the untrusted master
//   o_m_valid/o_m_payload   : sanitised request to the downstream slave
//   i_m_ready               : downstream ready
//   i_full                  : outstanding limit reached, blocks new issue
//   o_violation             : master broke the valid/payload-stable rule
module axi_lite_req_holder
  import axi_lite_verif_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = 32
) (
  input  logic                     i_aclk,
  input  logic                     i_areset,
  input  logic                     i_full,
  input  logic                     i_s_valid,
  input  logic [PAYLOAD_WIDTH-1:0] i_s_payload,
  output logic                     o_s_ready,
  output logic                     o_m_valid,
  output logic [PAYLOAD_WIDTH-1:0] o_m_payload,
  input  logic                     i_m_ready,
  output logic                     o_violation
);

  hold_state_t              r_state;
  hold_state_t              w_state_next;
  logic [PAYLOAD_WIDTH-1:0] r_hold;

  always_ff @(posedge i_aclk) begin
    if (i_areset) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_s_valid && !i_full && !i_m_ready) w_state_next = HOLD;
      HOLD:    if (i_m_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Payload is captured exactly when an offered request stalls.
  always_ff @(posedge i_aclk) begin
    if (i_areset)                                     r_hold <= '0;
    else if (r_state == IDLE && w_state_next == HOLD) r_hold <= i_s_payload;
  end

  always_comb begin
    o_m_valid   = 1'b0;
    o_m_payload = i_s_payload;
    o_s_ready   = 1'b0;
    o_violation = 1'b0;
    case (r_state)
      IDLE: begin
        o_m_valid   = i_s_valid & ~i_full;
        o_m_payload = i_s_payload;
        o_s_ready   = i_m_ready & ~i_full;
      end
      HOLD: begin
        // Downstream transfer always completes, even if upstream gave up.
        o_m_valid   = 1'b1;
        o_m_payload = r_hold;
        o_s_ready   = i_m_ready;
        o_violation = ~i_s_valid | (i_s_payload != r_hold);
      end
      default: begin
        o_m_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/axi_lite_master_verifier.sv
// AXI-Lite master-side protocol verifier.
// Repairs dropped/unstable requests, caps outstanding requests, times out
// responses the master refuses to accept, and reports errors.
//   aclk, areset             : clock, synchronous active-high reset
//   axi_lite_s               : slave port facing the untrusted master
//   axi_lite_m               : master port facing the downstream slave
//   timeout_error_irq        : level interrupt, any error present
//   timeout_status_vector    : sticky error bits {R_TO, B_TO, AR, W, AW}
//   timeout_error_clear      : one-cycle clear of sticky bits and timers
//   bresp_expected           : a fully issued write awaits its B
//   rresp_expected           : an issued read awaits its R
module axi_lite_master_verifier
  import axi_lite_verif_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int BTIMEOUT_CYCLES  = 127,
  parameter int RTIMEOUT_CYCLES  = 127,
  parameter int OUTSTANDING_WREQ = 8,
  parameter int OUTSTANDING_RREQ = 8
) (
  input  logic                aclk,
  input  logic                areset,
  axi_lite_if.slave           axi_lite_s,
  axi_lite_if.master          axi_lite_m,
  output logic                timeout_error_irq,
  output logic [ST_COUNT-1:0] timeout_status_vector,
  input  logic                timeout_error_clear,
  output logic                bresp_expected,
  output logic                rresp_expected
);

  localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int WPL_WIDTH  = AXI_DATA_WIDTH + STRB_WIDTH;
  localparam int WCNT_W     = cnt_width(OUTSTANDING_WREQ);
  localparam int RCNT_W     = cnt_width(OUTSTANDING_RREQ);
  localparam int BT_W       = $clog2(BTIMEOUT_CYCLES + 2);
  localparam int RT_W       = $clog2(RTIMEOUT_CYCLES + 2);

  localparam logic [WCNT_W-1:0] W_LIMIT = WCNT_W'(OUTSTANDING_WREQ);
  localparam logic [RCNT_W-1:0] R_LIMIT = RCNT_W'(OUTSTANDING_RREQ);
  localparam logic [WCNT_W-1:0] W_ONE   = WCNT_W'(1);
  localparam logic [RCNT_W-1:0] R_ONE   = RCNT_W'(1);
  localparam logic [BT_W-1:0]   B_LIMIT = BT_W'(BTIMEOUT_CYCLES);
  localparam logic [RT_W-1:0]   R_TLIM  = RT_W'(RTIMEOUT_CYCLES);
  localparam logic [BT_W-1:0]   BT_ONE  = BT_W'(1);
  localparam logic [RT_W-1:0]   RT_ONE  = RT_W'(1);

  logic [WCNT_W-1:0]   r_aw_out, w_aw_out_next;
  logic [WCNT_W-1:0]   r_w_out,  w_w_out_next;
  logic [RCNT_W-1:0]   r_ar_out, w_ar_out_next;
  logic [BT_W-1:0]     r_btimer;
  logic [RT_W-1:0]     r_rtimer;
  logic [ST_COUNT-1:0] r_status, w_status_next, w_set;
  logic                w_aw_full, w_w_full, w_ar_full;
  logic                w_aw_viol, w_w_viol, w_ar_viol;
  logic                w_b_timeout, w_r_timeout;
  logic                w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
  logic [WPL_WIDTH-1:0] w_m_wpayload;

  // ---------------- request channels ----------------
  axi_lite_req_holder #(.PAYLOAD_WIDTH(AXI_ADDR_WIDTH)) u_aw (
    .i_aclk      (aclk),
    .i_areset    (areset),
    .i_full      (w_aw_full),
    .i_s_valid   (axi_lite_s.awvalid),
    .i_s_payload (axi_lite_s.awaddr),
    .o_s_ready   (axi_lite_s.awready),
    .o_m_valid   (axi_lite_m.awvalid),
    .o_m_payload (axi_lite_m.awaddr),
    .i_m_ready   (axi_lite_m.awready),
    .o_violation (w_aw_viol)
  );

  axi_lite_req_holder #(.PAYLOAD_WIDTH(WPL_WIDTH)) u_w (
    .i_aclk      (aclk),
    .i_areset    (areset),
    .i_full      (w_w_full),
    .i_s_valid   (axi_lite_s.wvalid),
    .i_s_payload ({axi_lite_s.wdata, axi_lite_s.wstrb}),
    .o_s_ready   (axi_lite_s.wready),
    .o_m_valid   (axi_lite_m.wvalid),
    .o_m_payload (w_m_wpayload),
    .i_m_ready   (axi_lite_m.wready),
    .o_violation (w_w_viol)
  );

  assign axi_lite_m.wdata = w_m_wpayload[WPL_WIDTH-1:STRB_WIDTH];
  assign axi_lite_m.wstrb = w_m_wpayload[STRB_WIDTH-1:0];

  axi_lite_req_holder #(.PAYLOAD_WIDTH(AXI_ADDR_WIDTH)) u_ar (
    .i_aclk      (aclk),
    .i_areset    (areset),
    .i_full      (w_ar_full),
    .i_s_valid   (axi_lite_s.arvalid),
    .i_s_payload (axi_lite_s.araddr),
    .o_s_ready   (axi_lite_s.arready),
    .o_m_valid   (axi_lite_m.arvalid),
    .o_m_payload (axi_lite_m.araddr),
    .i_m_ready   (axi_lite_m.arready),
    .o_violation (w_ar_viol)
  );

  // ---------------- response channels: pure pass-through ----------------
  assign axi_lite_s.bresp  = axi_lite_m.bresp;
  assign axi_lite_s.bvalid = axi_lite_m.bvalid;
  assign axi_lite_m.bready = axi_lite_s.bready;
  assign axi_lite_s.rdata  = axi_lite_m.rdata;
  assign axi_lite_s.rresp  = axi_lite_m.rresp;
  assign axi_lite_s.rvalid = axi_lite_m.rvalid;
  assign axi_lite_m.rready = axi_lite_s.rready;

  assign w_aw_hs = axi_lite_m.awvalid & axi_lite_m.awready;
  assign w_w_hs  = axi_lite_m.wvalid  & axi_lite_m.wready;
  assign w_ar_hs = axi_lite_m.arvalid & axi_lite_m.arready;
  assign w_b_hs  = axi_lite_m.bvalid  & axi_lite_s.bready;
  assign w_r_hs  = axi_lite_m.rvalid  & axi_lite_s.rready;

  // ---------------- outstanding counters ----------------
  // Decrement saturates at zero so a stray response cannot wrap the count.
  always_comb begin
    w_aw_out_next = r_aw_out;
    if (w_aw_hs && !w_b_hs) begin
      if (r_aw_out != W_LIMIT) w_aw_out_next = r_aw_out + W_ONE;
    end else if (!w_aw_hs && w_b_hs) begin
      if (r_aw_out != '0) w_aw_out_next = r_aw_out - W_ONE;
    end
  end

  always_comb begin
    w_w_out_next = r_w_out;
    if (w_w_hs && !w_b_hs) begin
      if (r_w_out != W_LIMIT) w_w_out_next = r_w_out + W_ONE;
    end else if (!w_w_hs && w_b_hs) begin
      if (r_w_out != '0) w_w_out_next = r_w_out - W_ONE;
    end
  end

  always_comb begin
    w_ar_out_next = r_ar_out;
    if (w_ar_hs && !w_r_hs) begin
      if (r_ar_out != R_LIMIT) w_ar_out_next = r_ar_out + R_ONE;
    end else if (!w_ar_hs && w_r_hs) begin
      if (r_ar_out != '0) w_ar_out_next = r_ar_out - R_ONE;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_aw_out <= '0;
      r_w_out  <= '0;
      r_ar_out <= '0;
    end else begin
      r_aw_out <= w_aw_out_next;
      r_w_out  <= w_w_out_next;
      r_ar_out <= w_ar_out_next;
    end
  end

  assign w_aw_full = (r_aw_out == W_LIMIT);
  assign w_w_full  = (r_w_out  == W_LIMIT);
  assign w_ar_full = (r_ar_out == R_LIMIT);

  assign bresp_expected = (r_aw_out != '0) & (r_w_out != '0);
  assign rresp_expected = (r_ar_out != '0);

  // ---------------- response timers ----------------
  always_ff @(posedge aclk) begin
    if (areset || timeout_error_clear || w_b_hs)
      r_btimer <= '0;
    else if (axi_lite_m.bvalid && !axi_lite_s.bready && r_btimer != '1)
      r_btimer <= r_btimer + BT_ONE;
  end

  always_ff @(posedge aclk) begin
    if (areset || timeout_error_clear || w_r_hs)
      r_rtimer <= '0;
    else if (axi_lite_m.rvalid && !axi_lite_s.rready && r_rtimer != '1)
      r_rtimer <= r_rtimer + RT_ONE;
  end

  assign w_b_timeout = (r_btimer > B_LIMIT);
  assign w_r_timeout = (r_rtimer > R_TLIM);

  // ---------------- sticky status ----------------
  assign w_set[ST_AW] = w_aw_viol;
  assign w_set[ST_W]  = w_w_viol;
  assign w_set[ST_AR] = w_ar_viol;
  assign w_set[ST_B]  = w_b_timeout;
  assign w_set[ST_R]  = w_r_timeout;

  // Clear wins over a set detected in the same cycle.
  for (genvar gi = 0; gi < ST_COUNT; gi++) begin : g_sticky
    assign w_status_next[gi] = ~timeout_error_clear & (r_status[gi] | w_set[gi]);
  end

  always_ff @(posedge aclk) begin
    if (areset) r_status <= '0;
    else        r_status <= w_status_next;
  end

  assign timeout_status_vector = r_status;
  // Raw timeouts bypass the sticky register so the irq rises on detection.
  assign timeout_error_irq = (|r_status) | w_b_timeout | w_r_timeout;

endmodule

// File: tb/tb_axi_lite_master_verifier.sv
module tb_axi_lite_master_verifier;
  import axi_lite_verif_pkg::*;

  logic       aclk = 1'b0;
  logic       areset;
  logic       timeout_error_irq;
  logic [4:0] timeout_status_vector;
  logic       timeout_error_clear;
  logic       bresp_expected;
  logic       rresp_expected;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_aw_q[$];
  logic [31:0] exp_ar_q[$];
  logic [35:0] exp_w_q[$];

  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();
  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();

  axi_lite_master_verifier dut (
    .aclk                  (aclk),
    .areset                (areset),
    .axi_lite_s            (s_if),
    .axi_lite_m            (m_if),
    .timeout_error_irq     (timeout_error_irq),
    .timeout_status_vector (timeout_status_vector),
    .timeout_error_clear   (timeout_error_clear),
    .bresp_expected        (bresp_expected),
    .rresp_expected        (rresp_expected)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance to just after the next rising edge, then let comb logic settle.
  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Downstream scoreboard: each handshake pops the request the bench expects.
  always @(negedge aclk) begin
    if (!areset) begin
      if (m_if.awvalid && m_if.awready) begin
        $display("aw  addr=%h", m_if.awaddr);
        if (exp_aw_q.size() == 0) check("aw_unexpected", 64'(m_if.awaddr), 64'hFFFF_FFFF_FFFF);
        else check("aw_addr", 64'(m_if.awaddr), 64'(exp_aw_q.pop_front()));
      end
      if (m_if.wvalid && m_if.wready) begin
        $display("w   data=%h strb=%h", m_if.wdata, m_if.wstrb);
        if (exp_w_q.size() == 0) check("w_unexpected", 64'({m_if.wdata, m_if.wstrb}), 64'hFFFF_FFFF_FFFF);
        else check("w_payload", 64'({m_if.wdata, m_if.wstrb}), 64'(exp_w_q.pop_front()));
      end
      if (m_if.arvalid && m_if.arready) begin
        $display("ar  addr=%h", m_if.araddr);
        if (exp_ar_q.size() == 0) check("ar_unexpected", 64'(m_if.araddr), 64'hFFFF_FFFF_FFFF);
        else check("ar_addr", 64'(m_if.araddr), 64'(exp_ar_q.pop_front()));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    timeout_error_clear = 1'b0;
    s_if.awaddr = '0; s_if.awvalid = 0;
    s_if.wdata = '0; s_if.wstrb = '0; s_if.wvalid = 0;
    s_if.bready = 0;
    s_if.araddr = '0; s_if.arvalid = 0;
    s_if.rready = 0;
    m_if.awready = 0; m_if.wready = 0; m_if.arready = 0;
    m_if.bresp = RESP_OKAY; m_if.bvalid = 0;
    m_if.rdata = '0; m_if.rresp = RESP_OKAY; m_if.rvalid = 0;

    // ---- reset state ----
    cyc();
    cyc();
    check("rst_awvalid", 64'(m_if.awvalid), 0);
    check("rst_wvalid", 64'(m_if.wvalid), 0);
    check("rst_arvalid", 64'(m_if.arvalid), 0);
    check("rst_irq", 64'(timeout_error_irq), 0);
    check("rst_status", 64'(timeout_status_vector), 0);
    check("rst_bexp", 64'(bresp_expected), 0);
    check("rst_rexp", 64'(rresp_expected), 0);
    areset = 1'b0;
    cyc();

    // ---- 1: AW valid dropped while awready is low ----
    s_if.awvalid = 1; s_if.awaddr = 32'h10;
    exp_aw_q.push_back(32'h10);
    settle();
    check("t1_pass_valid", 64'(m_if.awvalid), 1);
    check("t1_pass_addr", 64'(m_if.awaddr), 64'h10);
    check("t1_s_ready_low", 64'(s_if.awready), 0);
    cyc();
    s_if.awvalid = 0; s_if.awaddr = 32'h0;
    settle();
    check("t1_hold_valid", 64'(m_if.awvalid), 1);
    check("t1_hold_addr", 64'(m_if.awaddr), 64'h10);
    check("t1_status_not_yet", 64'(timeout_status_vector), 0);
    cyc();
    check("t1_status_aw", 64'(timeout_status_vector), 64'b00001);
    check("t1_irq", 64'(timeout_error_irq), 1);
    check("t1_hold_addr2", 64'(m_if.awaddr), 64'h10);
    cyc();
    m_if.awready = 1;
    settle();
    check("t1_hold_valid_at_hs", 64'(m_if.awvalid), 1);
    cyc();
    m_if.awready = 0;
    settle();
    check("t1_idle_after_hs", 64'(m_if.awvalid), 0);
    check("t1_bexp_aw_only", 64'(bresp_expected), 0);
    timeout_error_clear = 1;
    cyc();
    timeout_error_clear = 0;
    settle();
    check("t1_clear_status", 64'(timeout_status_vector), 0);
    check("t1_clear_irq", 64'(timeout_error_irq), 0);

    // ---- W zero-latency pass-through ----
    s_if.wvalid = 1; s_if.wdata = 32'hDEAD_BEEF; s_if.wstrb = 4'hF; m_if.wready = 1;
    exp_w_q.push_back({32'hDEAD_BEEF, 4'hF});
    settle();
    check("w_pass_ready", 64'(s_if.wready), 1);
    cyc();
    s_if.wvalid = 0; m_if.wready = 0;
    settle();
    check("w_bexp_set", 64'(bresp_expected), 1);
    check("w_status_clean", 64'(timeout_status_vector), 0);

    // ---- 5: AW+W handshake together with a B handshake ----
    s_if.awvalid = 1; s_if.awaddr = 32'h40; m_if.awready = 1;
    s_if.wvalid = 1; s_if.wdata = 32'h1234_5678; s_if.wstrb = 4'h3; m_if.wready = 1;
    m_if.bvalid = 1; m_if.bresp = RESP_EXOKAY; s_if.bready = 1;
    exp_aw_q.push_back(32'h40);
    exp_w_q.push_back({32'h1234_5678, 4'h3});
    settle();
    check("t5_bvalid_pass", 64'(s_if.bvalid), 1);
    check("t5_bresp_pass", 64'(s_if.bresp), 64'(RESP_EXOKAY));
    cyc();
    s_if.awvalid = 0; m_if.awready = 0; s_if.wvalid = 0; m_if.wready = 0;
    m_if.bvalid = 0; s_if.bready = 0;
    settle();
    check("t5_bexp_kept", 64'(bresp_expected), 1);
    m_if.bvalid = 1; s_if.bready = 1;
    cyc();
    m_if.bvalid = 0; s_if.bready = 0;
    settle();
    check("t5_counts_were_one", 64'(bresp_expected), 0);

    // ---- 2: AR address changes while arready is low ----
    s_if.arvalid = 1; s_if.araddr = 32'h20;
    exp_ar_q.push_back(32'h20);
    cyc();
    s_if.araddr = 32'h24;
    settle();
    check("t2_hold_addr", 64'(m_if.araddr), 64'h20);
    check("t2_hold_valid", 64'(m_if.arvalid), 1);
    cyc();
    check("t2_status_ar", 64'(timeout_status_vector), 64'b00100);
    check("t2_rexp_not_issued", 64'(rresp_expected), 0);
    m_if.arready = 1; s_if.arvalid = 0;
    settle();
    check("t2_hs_addr", 64'(m_if.araddr), 64'h20);
    cyc();
    check("t2_rexp", 64'(rresp_expected), 1);
    timeout_error_clear = 1;
    cyc();
    timeout_error_clear = 0;
    settle();
    check("t2_clear", 64'(timeout_status_vector), 0);

    // ---- 3: outstanding read limit ----
    for (int i = 1; i < 8; i++) begin
      s_if.arvalid = 1; s_if.araddr = 32'h100 + 32'(4 * i);
      exp_ar_q.push_back(32'h100 + 32'(4 * i));
      cyc();
    end
    s_if.araddr = 32'h200;
    settle();
    check("t3_full_s_ready", 64'(s_if.arready), 0);
    check("t3_full_m_valid", 64'(m_if.arvalid), 0);
    check("t3_full_rexp", 64'(rresp_expected), 1);
    m_if.rvalid = 1; m_if.rdata = 32'hCAFE_0001; m_if.rresp = RESP_SLVERR; s_if.rready = 1;
    settle();
    check("t3_rdata_pass", 64'(s_if.rdata), 64'hCAFE_0001);
    check("t3_rresp_pass", 64'(s_if.rresp), 64'(RESP_SLVERR));
    check("t3_still_blocked", 64'(m_if.arvalid), 0);
    cyc();
    m_if.rvalid = 0; s_if.rready = 0;
    exp_ar_q.push_back(32'h200);
    settle();
    check("t3_ninth_valid", 64'(m_if.arvalid), 1);
    check("t3_ninth_ready", 64'(s_if.arready), 1);
    check("t3_ninth_addr", 64'(m_if.araddr), 64'h200);
    check("t3_rexp_mid", 64'(rresp_expected), 1);
    cyc();
    s_if.arvalid = 0; m_if.arready = 0;
    m_if.rvalid = 1; s_if.rready = 1;
    for (int i = 0; i < 8; i++) begin
      settle();
      check("t3_drain_rexp", 64'(rresp_expected), 1);
      cyc();
    end
    m_if.rvalid = 0; s_if.rready = 0;
    settle();
    check("t3_drained", 64'(rresp_expected), 0);
    check("t3_status_clean", 64'(timeout_status_vector), 0);

    // ---- 4: B timeout ----
    m_if.bvalid = 1; m_if.bresp = RESP_OKAY; s_if.bready = 0;
    repeat (127) cyc();
    check("t4_irq_127", 64'(timeout_error_irq), 0);
    cyc();
    check("t4_irq_128", 64'(timeout_error_irq), 1);
    check("t4_status_lag", 64'(timeout_status_vector), 0);
    cyc();
    check("t4_status_b", 64'(timeout_status_vector), 64'b01000);
    timeout_error_clear = 1;
    cyc();
    timeout_error_clear = 0;
    settle();
    check("t4_clear_status", 64'(timeout_status_vector), 0);
    check("t4_clear_irq", 64'(timeout_error_irq), 0);
    repeat (127) cyc();
    check("t4_restart_127", 64'(timeout_error_irq), 0);
    s_if.bready = 1;
    cyc();
    m_if.bvalid = 0; s_if.bready = 0;
    settle();
    check("t4_unexp_b_sat", 64'(bresp_expected), 0);
    s_if.awvalid = 1; s_if.awaddr = 32'h50; m_if.awready = 1;
    s_if.wvalid = 1; s_if.wdata = 32'h5555_AAAA; s_if.wstrb = 4'h8; m_if.wready = 1;
    exp_aw_q.push_back(32'h50);
    exp_w_q.push_back({32'h5555_AAAA, 4'h8});
    cyc();
    s_if.awvalid = 0; m_if.awready = 0; s_if.wvalid = 0; m_if.wready = 0;
    settle();
    check("t4_no_wrap", 64'(bresp_expected), 1);
    m_if.bvalid = 1; s_if.bready = 1;
    cyc();
    m_if.bvalid = 0; s_if.bready = 0;
    settle();
    check("t4_b_done", 64'(bresp_expected), 0);

    // ---- R timeout ----
    m_if.rvalid = 1; m_if.rresp = RESP_DECERR; s_if.rready = 0;
    settle();
    check("r_resp_pass", 64'(s_if.rresp), 64'(RESP_DECERR));
    repeat (128) cyc();
    check("r_irq_128", 64'(timeout_error_irq), 1);
    cyc();
    check("r_status", 64'(timeout_status_vector), 64'b10000);
    s_if.rready = 1;
    cyc();
    m_if.rvalid = 0; s_if.rready = 0;
    timeout_error_clear = 1;
    cyc();
    timeout_error_clear = 0;
    settle();
    check("r_cleared", 64'(timeout_status_vector), 0);
    check("r_rexp_sat", 64'(rresp_expected), 0);

    // ---- 6: reset while AW is in HOLD ----
    s_if.arvalid = 1; s_if.araddr = 32'h300; m_if.arready = 1;
    exp_ar_q.push_back(32'h300);
    cyc();
    s_if.arvalid = 0; m_if.arready = 0;
    settle();
    check("t6_rexp_pre", 64'(rresp_expected), 1);
    s_if.awvalid = 1; s_if.awaddr = 32'h80; m_if.awready = 0;
    cyc();
    areset = 1; s_if.awvalid = 0;
    cyc();
    check("t6_awvalid", 64'(m_if.awvalid), 0);
    check("t6_status", 64'(timeout_status_vector), 0);
    check("t6_rexp", 64'(rresp_expected), 0);
    check("t6_irq", 64'(timeout_error_irq), 0);
    areset = 0;
    cyc();
    check("t6_post_awvalid", 64'(m_if.awvalid), 0);
    check("t6_post_status", 64'(timeout_status_vector), 0);
    s_if.awvalid = 1; s_if.awaddr = 32'h84; m_if.awready = 1;
    s_if.wvalid = 1; s_if.wdata = 32'h0F0F_0F0F; s_if.wstrb = 4'h1; m_if.wready = 1;
    exp_aw_q.push_back(32'h84);
    exp_w_q.push_back({32'h0F0F_0F0F, 4'h1});
    cyc();
    s_if.awvalid = 0; m_if.awready = 0; s_if.wvalid = 0; m_if.wready = 0;
    settle();
    check("t6_counts_from_zero", 64'(bresp_expected), 1);
    cyc();

    check("sb_aw_empty", 64'(exp_aw_q.size()), 0);
    check("sb_w_empty", 64'(exp_w_q.size()), 0);
    check("sb_ar_empty", 64'(exp_ar_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
